// File: rtl/atm_keypad_entry.sv
// Keypad front end for the ATM controller: builds language, account, PIN,
// operation, destination and amount fields from key presses and presents them.
module atm_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        atm_ready,
    output logic        LC,
    output logic [1:0]  lang,
    output logic [11:0] Account_Number,
    output logic [11:0] PIN,
    output logic [11:0] Destination_Account,
    output logic [11:0] Deposit_Amount,
    output logic [11:0] WithDraw_Amount,
    output logic [11:0] Transfer_Amount,
    output logic [2:0]  Operation,
    output logic        txn_valid,
    output logic [2:0]  entry_state,
    output logic        err,
    output logic        timeout
);
    localparam int IW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        LANG    = 3'd0,
        ACCT    = 3'd1,
        PINE    = 3'd2,
        OP      = 3'd3,
        DST     = 3'd4,
        AMT     = 3'd5,
        PRESENT = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic [11:0]   acc, acc_nxt;
    logic [3:0]    op_pend, op_pend_nxt;
    logic          op_have, op_have_nxt;
    logic [IW-1:0] idle, idle_nxt;

    logic          lc_nxt;
    logic [1:0]    lang_nxt;
    logic [11:0]   acct_nxt, pin_nxt, dst_nxt, dep_nxt, wd_nxt, tr_nxt;
    logic [2:0]    op_nxt;
    logic          txn_nxt, err_nxt, tmo_nxt;

    logic          is_digit, is_clear, is_enter, is_cancel;
    logic          handshake, counting, expired, abort;
    logic [13:0]   acc_prod;
    logic [11:0]   field_cur, field_nxt;

    assign is_digit    = key_valid && (key_code <= 4'd9);
    assign is_clear    = key_valid && (key_code == 4'hA);
    assign is_enter    = key_valid && (key_code == 4'hB);
    assign is_cancel   = key_valid && (key_code == 4'hC);
    assign handshake   = (state == PRESENT) && txn_valid && atm_ready;
    assign counting    = (state == ACCT) || (state == PINE) || (state == OP) ||
                         (state == DST) || (state == AMT);
    assign expired     = counting && !key_valid && (idle == IW'(TIMEOUT_CYCLES - 1));
    assign acc_prod    = {2'b00, acc} * 14'd10 + {10'd0, key_code};
    assign entry_state = state;

    // State register plus every registered output and datapath register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= LANG;
            cnt                 <= 3'd0;
            acc                 <= 12'd0;
            op_pend             <= 4'd0;
            op_have             <= 1'b0;
            idle                <= '0;
            LC                  <= 1'b0;
            lang                <= 2'd0;
            Account_Number      <= 12'd0;
            PIN                 <= 12'd0;
            Destination_Account <= 12'd0;
            Deposit_Amount      <= 12'd0;
            WithDraw_Amount     <= 12'd0;
            Transfer_Amount     <= 12'd0;
            Operation           <= 3'd0;
            txn_valid           <= 1'b0;
            err                 <= 1'b0;
            timeout             <= 1'b0;
        end else begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            acc                 <= acc_nxt;
            op_pend             <= op_pend_nxt;
            op_have             <= op_have_nxt;
            idle                <= idle_nxt;
            LC                  <= lc_nxt;
            lang                <= lang_nxt;
            Account_Number      <= acct_nxt;
            PIN                 <= pin_nxt;
            Destination_Account <= dst_nxt;
            Deposit_Amount      <= dep_nxt;
            WithDraw_Amount     <= wd_nxt;
            Transfer_Amount     <= tr_nxt;
            Operation           <= op_nxt;
            txn_valid           <= txn_nxt;
            err                 <= err_nxt;
            timeout             <= tmo_nxt;
        end
    end

    // Handshake beats CANCEL, CANCEL beats timeout, and any key beats timeout.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        tmo_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (handshake) begin
            if (Operation == 3'd4) begin
                state_nxt = LANG;
                abort     = 1'b1;
            end else begin
                state_nxt = OP;
            end
        end else if (is_cancel) begin
            state_nxt = LANG;
            abort     = 1'b1;
        end else if (expired) begin
            state_nxt = LANG;
            abort     = 1'b1;
            tmo_nxt   = 1'b1;
        end else begin
            case (state)
                LANG: begin
                    if (is_digit && (key_code == 4'd1 || key_code == 4'd2)) state_nxt = ACCT;
                end
                ACCT, PINE, DST: begin
                    if (is_digit && cnt == 3'd3) err_nxt = 1'b1;
                    if (is_enter) begin
                        if (cnt != 3'd3)        err_nxt   = 1'b1;
                        else if (state == ACCT) state_nxt = PINE;
                        else if (state == PINE) state_nxt = OP;
                        else                    state_nxt = AMT;
                    end
                end
                OP: begin
                    if (is_enter) begin
                        if (!op_have || op_pend > 4'd4) begin
                            err_nxt = 1'b1;
                        end else begin
                            case (op_pend[2:0])
                                3'd0, 3'd1: state_nxt = AMT;
                                3'd3:       state_nxt = DST;
                                default:    state_nxt = PRESENT;
                            endcase
                        end
                    end
                end
                AMT: begin
                    if (is_digit && (cnt == 3'd4 || acc_prod > 14'd4095)) err_nxt = 1'b1;
                    if (is_enter) begin
                        if (acc == 12'd0) err_nxt   = 1'b1;
                        else              state_nxt = PRESENT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (state)
            ACCT:    field_cur = Account_Number;
            PINE:    field_cur = PIN;
            DST:     field_cur = Destination_Account;
            default: field_cur = 12'd0;
        endcase
    end

    // Datapath and output next values; abort and state changes scrub entry context.
    always_comb begin
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        op_pend_nxt = op_pend;
        op_have_nxt = op_have;
        lc_nxt      = LC;
        lang_nxt    = lang;
        acct_nxt    = Account_Number;
        pin_nxt     = PIN;
        dst_nxt     = Destination_Account;
        dep_nxt     = Deposit_Amount;
        wd_nxt      = WithDraw_Amount;
        tr_nxt      = Transfer_Amount;
        op_nxt      = Operation;
        field_nxt   = field_cur;
        if (abort) begin
            lc_nxt   = 1'b0;
            lang_nxt = 2'd0;
            acct_nxt = 12'd0;
            pin_nxt  = 12'd0;
            dst_nxt  = 12'd0;
            dep_nxt  = 12'd0;
            wd_nxt   = 12'd0;
            tr_nxt   = 12'd0;
            op_nxt   = 3'd0;
        end else if (handshake) begin
            dst_nxt = 12'd0;
            dep_nxt = 12'd0;
            wd_nxt  = 12'd0;
            tr_nxt  = 12'd0;
            op_nxt  = 3'd0;
        end else begin
            case (state)
                LANG: begin
                    if (state_nxt == ACCT) begin
                        lang_nxt = key_code[1:0];
                        lc_nxt   = 1'b1;
                    end
                end
                ACCT, PINE, DST: begin
                    if (is_clear || (is_enter && cnt != 3'd3)) begin
                        field_nxt = 12'd0;
                        cnt_nxt   = 3'd0;
                    end else if (is_digit && cnt != 3'd3) begin
                        field_nxt = {field_cur[7:0], key_code};
                        cnt_nxt   = cnt + 3'd1;
                    end
                    case (state)
                        ACCT:    acct_nxt = field_nxt;
                        PINE:    pin_nxt  = field_nxt;
                        default: dst_nxt  = field_nxt;
                    endcase
                end
                OP: begin
                    if (is_clear) begin
                        op_pend_nxt = 4'd0;
                        op_have_nxt = 1'b0;
                    end else if (is_digit) begin
                        op_pend_nxt = key_code;
                        op_have_nxt = 1'b1;
                    end else if (state_nxt != OP) begin
                        op_nxt = op_pend[2:0];
                    end
                end
                AMT: begin
                    if (is_clear) begin
                        acc_nxt = 12'd0;
                        cnt_nxt = 3'd0;
                    end else if (is_digit && !err_nxt) begin
                        acc_nxt = acc_prod[11:0];
                        cnt_nxt = cnt + 3'd1;
                    end else if (state_nxt == PRESENT) begin
                        dep_nxt = (Operation == 3'd0) ? acc : 12'd0;
                        wd_nxt  = (Operation == 3'd1) ? acc : 12'd0;
                        tr_nxt  = (Operation == 3'd3) ? acc : 12'd0;
                    end
                end
                default: ;
            endcase
        end
        if (abort || state_nxt != state) begin
            cnt_nxt     = 3'd0;
            acc_nxt     = 12'd0;
            op_pend_nxt = 4'd0;
            op_have_nxt = 1'b0;
        end
        txn_nxt = (state_nxt == PRESENT);
        if (key_valid || state_nxt != state || !counting) idle_nxt = '0;
        else                                               idle_nxt = idle + IW'(1);
    end
endmodule

// File: tb/tb_atm_keypad_entry.sv
// Bench for atm_keypad_entry: vector table, directed corner sequences and a
// random run, all checked every cycle against a digit-list reference model.
module tb_atm_keypad_entry;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst, key_valid, atm_ready;
    logic [3:0]  key_code;
    logic        LC, txn_valid, err, timeout;
    logic [1:0]  lang;
    logic [11:0] Account_Number, PIN, Destination_Account;
    logic [11:0] Deposit_Amount, WithDraw_Amount, Transfer_Amount;
    logic [2:0]  Operation, entry_state;

    int n_pass = 0;
    int n_total = 0;

    atm_keypad_entry #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .atm_ready(atm_ready), .LC(LC), .lang(lang),
        .Account_Number(Account_Number), .PIN(PIN),
        .Destination_Account(Destination_Account),
        .Deposit_Amount(Deposit_Amount), .WithDraw_Amount(WithDraw_Amount),
        .Transfer_Amount(Transfer_Amount), .Operation(Operation),
        .txn_valid(txn_valid), .entry_state(entry_state), .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: fields kept as digit lists, amounts as plain integers.
    int m_st, m_lang, m_lc, m_op, m_pend, m_amt_val, m_amt_n, m_quiet;
    int m_dep, m_wd, m_tr;
    int fd[3][3];
    int fn[3];
    bit m_err, m_tmo;

    function automatic void model_reset();
        m_st = 0; m_lang = 0; m_lc = 0; m_op = 0; m_pend = -1;
        m_amt_val = 0; m_amt_n = 0; m_quiet = 0;
        m_dep = 0; m_wd = 0; m_tr = 0;
        for (int k = 0; k < 3; k++) fn[k] = 0;
    endfunction

    function automatic int field_val(input int k);
        int v = 0;
        for (int i = 0; i < fn[k]; i++) v = v * 16 + fd[k][i];
        return v;
    endfunction

    task automatic model_edge(input bit kv, input int kc, input bit rdy, input bit r);
        int prev, k;
        bit was_counting;
        prev = m_st;
        was_counting = (m_st >= 1 && m_st <= 5);
        m_err = 0;
        m_tmo = 0;
        if (r) begin
            model_reset();
        end else if (m_st == 6 && rdy) begin
            if (m_op == 4) model_reset();
            else begin
                m_st = 3; m_op = 0; m_dep = 0; m_wd = 0; m_tr = 0; fn[2] = 0;
            end
        end else if (kv && kc == 12) begin
            model_reset();
        end else if (!kv && was_counting && m_quiet == TO - 1) begin
            model_reset();
            m_tmo = 1;
        end else if (kv && kc <= 11) begin
            case (m_st)
                0: if (kc == 1 || kc == 2) begin m_lang = kc; m_lc = 1; m_st = 1; end
                1, 2, 4: begin
                    k = (m_st == 1) ? 0 : (m_st == 2) ? 1 : 2;
                    if (kc <= 9) begin
                        if (fn[k] < 3) begin fd[k][fn[k]] = kc; fn[k]++; end
                        else m_err = 1;
                    end else if (kc == 10) begin
                        fn[k] = 0;
                    end else if (fn[k] == 3) begin
                        m_st = (m_st == 1) ? 2 : (m_st == 2) ? 3 : 5;
                    end else begin
                        fn[k] = 0;
                        m_err = 1;
                    end
                end
                3: begin
                    if (kc <= 9) m_pend = kc;
                    else if (kc == 10) m_pend = -1;
                    else if (m_pend < 0 || m_pend > 4) m_err = 1;
                    else begin
                        m_op = m_pend;
                        m_st = (m_op <= 1) ? 5 : (m_op == 3) ? 4 : 6;
                    end
                end
                5: begin
                    if (kc <= 9) begin
                        if (m_amt_n >= 4 || m_amt_val * 10 + kc > 4095) m_err = 1;
                        else begin m_amt_val = m_amt_val * 10 + kc; m_amt_n++; end
                    end else if (kc == 10) begin
                        m_amt_val = 0; m_amt_n = 0;
                    end else if (m_amt_val == 0) begin
                        m_err = 1;
                    end else begin
                        if (m_op == 0) m_dep = m_amt_val;
                        else if (m_op == 1) m_wd = m_amt_val;
                        else m_tr = m_amt_val;
                        m_st = 6;
                    end
                end
                default: ;
            endcase
        end
        if (m_st != prev) begin m_pend = -1; m_amt_val = 0; m_amt_n = 0; end
        if (kv || m_st != prev || !(m_st >= 1 && m_st <= 5)) m_quiet = 0;
        else m_quiet++;
    endtask

    function automatic logic [83:0] model_vec();
        return {1'(m_lc), 2'(m_lang), 12'(field_val(0)), 12'(field_val(1)), 12'(field_val(2)),
                12'(m_dep), 12'(m_wd), 12'(m_tr), 3'(m_op), (m_st == 6), 3'(m_st), m_err, m_tmo};
    endfunction

    function automatic logic [83:0] dut_vec();
        return {LC, lang, Account_Number, PIN, Destination_Account, Deposit_Amount,
                WithDraw_Amount, Transfer_Amount, Operation, txn_valid, entry_state, err, timeout};
    endfunction

    task automatic check_output(input string name, input logic [83:0] got, input logic [83:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic apply_stimulus(input bit kv, input int kc, input bit rdy, input bit r);
        @(negedge clk);
        key_valid = kv;
        key_code  = 4'(kc);
        atm_ready = rdy;
        rst       = r;
        @(posedge clk);
        model_edge(kv, kc, rdy, r);
        #1;
        check_output("model", dut_vec(), model_vec());
    endtask

    task automatic key(input int kc);
        apply_stimulus(1'b1, kc, 1'b0, 1'b0);
    endtask

    task automatic keys(input int ks[$]);
        foreach (ks[i]) key(ks[i]);
    endtask

    typedef struct {
        bit          kv;
        logic [3:0]  kc;
        bit          rdy;
        logic [2:0]  st;
        bit          e;
        bit          tv;
        logic [11:0] acct;
        logic [11:0] pin;
        logic [2:0]  op;
        logic [11:0] wd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit kv, input logic [3:0] kc, input bit rdy,
                                input logic [2:0] st, input bit e, input bit tv,
                                input logic [11:0] acct, input logic [11:0] pin,
                                input logic [2:0] op, input logic [11:0] wd);
        vec_t v;
        v.kv = kv; v.kc = kc; v.rdy = rdy; v.st = st; v.e = e; v.tv = tv;
        v.acct = acct; v.pin = pin; v.op = op; v.wd = wd;
        tbl.push_back(v);
    endfunction

    function automatic int rand_key();
        int p = $urandom_range(0, 99);
        if (p < 50) return $urandom_range(0, 9);
        if (p < 65) return $urandom_range(0, 4);
        if (p < 82) return 11;
        if (p < 87) return 10;
        if (p < 90) return 12;
        return $urandom_range(13, 15);
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [83:0] stall_exp;
        int kc;
        model_reset();
        key_valid = 0; key_code = 0; atm_ready = 0; rst = 1;
        apply_stimulus(0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        check_output("reset_state", dut_vec(), 84'd0);
        apply_stimulus(0, 0, 0, 0);

        // Basic withdraw, OP error, cancel, then account field errors.
        add(1, 4'h1, 0, 3'd1, 0, 0, 12'h000, 12'h000, 3'd0, 12'd0);
        add(1, 4'h1, 0, 3'd1, 0, 0, 12'h001, 12'h000, 3'd0, 12'd0);
        add(1, 4'h2, 0, 3'd1, 0, 0, 12'h012, 12'h000, 3'd0, 12'd0);
        add(1, 4'h3, 0, 3'd1, 0, 0, 12'h123, 12'h000, 3'd0, 12'd0);
        add(1, 4'hB, 0, 3'd2, 0, 0, 12'h123, 12'h000, 3'd0, 12'd0);
        add(1, 4'h4, 0, 3'd2, 0, 0, 12'h123, 12'h004, 3'd0, 12'd0);
        add(1, 4'h5, 0, 3'd2, 0, 0, 12'h123, 12'h045, 3'd0, 12'd0);
        add(1, 4'h6, 0, 3'd2, 0, 0, 12'h123, 12'h456, 3'd0, 12'd0);
        add(1, 4'hB, 0, 3'd3, 0, 0, 12'h123, 12'h456, 3'd0, 12'd0);
        add(1, 4'h1, 0, 3'd3, 0, 0, 12'h123, 12'h456, 3'd0, 12'd0);
        add(1, 4'hB, 0, 3'd5, 0, 0, 12'h123, 12'h456, 3'd1, 12'd0);
        add(1, 4'h2, 0, 3'd5, 0, 0, 12'h123, 12'h456, 3'd1, 12'd0);
        add(1, 4'h5, 0, 3'd5, 0, 0, 12'h123, 12'h456, 3'd1, 12'd0);
        add(1, 4'h0, 0, 3'd5, 0, 0, 12'h123, 12'h456, 3'd1, 12'd0);
        add(1, 4'hB, 0, 3'd6, 0, 1, 12'h123, 12'h456, 3'd1, 12'd250);
        add(0, 4'h0, 1, 3'd3, 0, 0, 12'h123, 12'h456, 3'd0, 12'd0);
        add(1, 4'h7, 0, 3'd3, 0, 0, 12'h123, 12'h456, 3'd0, 12'd0);
        add(1, 4'hB, 0, 3'd3, 1, 0, 12'h123, 12'h456, 3'd0, 12'd0);
        add(1, 4'hC, 0, 3'd0, 0, 0, 12'h000, 12'h000, 3'd0, 12'd0);
        add(1, 4'h2, 0, 3'd1, 0, 0, 12'h000, 12'h000, 3'd0, 12'd0);
        add(1, 4'h1, 0, 3'd1, 0, 0, 12'h001, 12'h000, 3'd0, 12'd0);
        add(1, 4'h2, 0, 3'd1, 0, 0, 12'h012, 12'h000, 3'd0, 12'd0);
        add(1, 4'hB, 0, 3'd1, 1, 0, 12'h000, 12'h000, 3'd0, 12'd0);
        add(1, 4'h1, 0, 3'd1, 0, 0, 12'h001, 12'h000, 3'd0, 12'd0);
        add(1, 4'h2, 0, 3'd1, 0, 0, 12'h012, 12'h000, 3'd0, 12'd0);
        add(1, 4'h3, 0, 3'd1, 0, 0, 12'h123, 12'h000, 3'd0, 12'd0);
        add(1, 4'h4, 0, 3'd1, 1, 0, 12'h123, 12'h000, 3'd0, 12'd0);
        add(1, 4'hE, 0, 3'd1, 0, 0, 12'h123, 12'h000, 3'd0, 12'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i].kv, int'(tbl[i].kc), tbl[i].rdy, 1'b0);
            check_output($sformatf("table[%0d]", i),
                         84'({entry_state, err, txn_valid, Account_Number, PIN, Operation, WithDraw_Amount}),
                         84'({tbl[i].st, tbl[i].e, tbl[i].tv, tbl[i].acct, tbl[i].pin, tbl[i].op, tbl[i].wd}));
        end

        // Transfer at the amount ceiling, then a stalled handshake.
        keys('{11, 4, 5, 6, 11, 3, 11, 7, 8, 9, 11, 4, 0, 9, 5, 11});
        check_output("xfer_dst", 84'(Destination_Account), 84'h789);
        check_output("xfer_amt", 84'(Transfer_Amount), 84'd4095);
        stall_exp = {1'b1, 2'd2, 12'h123, 12'h456, 12'h789, 12'd0, 12'd0, 12'd4095,
                     3'd3, 1'b1, 3'd6, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            kc = $urandom_range(0, 11);
            apply_stimulus(1'b1, kc, 1'b0, 1'b0);
            check_output($sformatf("stall[%0d]", i), dut_vec(), stall_exp);
        end
        apply_stimulus(1'b1, 12, 1'b1, 1'b0);
        check_output("hs_beats_cancel", 84'({entry_state, Account_Number, Destination_Account, Transfer_Amount}),
                     84'({3'd3, 12'h123, 12'h000, 12'd0}));

        keys('{3, 11, 7, 8, 9, 11, 4, 0, 9, 6});
        check_output("amt_overflow_err", 84'(err), 84'd1);
        key(11);
        check_output("amt_kept_409", 84'(Transfer_Amount), 84'd409);
        apply_stimulus(1'b0, 0, 1'b1, 1'b0);

        // Exit transfer aborts the session without an err pulse.
        keys('{4, 11});
        apply_stimulus(1'b0, 0, 1'b1, 1'b0);
        check_output("exit_abort", dut_vec(), 84'd0);

        // Inactivity timeout fires on the eighth idle edge after the last key.
        keys('{1, 1, 2, 3, 11, 4, 5});
        for (int i = 1; i <= TO; i++) begin
            apply_stimulus(1'b0, 0, 1'b0, 1'b0);
            check_output($sformatf("timeout_at_%0d", i), 84'(timeout), 84'(i == TO));
        end
        check_output("timeout_outputs", dut_vec(), 84'd1);

        keys('{1, 1, 2, 3, 11, 4, 5});
        for (int i = 1; i < TO; i++) apply_stimulus(1'b0, 0, 1'b0, 1'b0);
        key(6);
        check_output("key_beats_timeout", 84'({timeout, entry_state, PIN}), 84'({1'b0, 3'd2, 12'h456}));
        key(12);

        // Synchronous reset in the middle of amount entry.
        keys('{1, 1, 2, 3, 11, 4, 5, 6, 11, 0, 11, 5, 5});
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        check_output("rst_mid_amt", dut_vec(), 84'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                for (int j = 0; j < TO + 1; j++) apply_stimulus(1'b0, 0, 1'b0, 1'b0);
            end else begin
                apply_stimulus($urandom_range(0, 9) < 7, rand_key(), $urandom_range(0, 2) == 0,
                               $urandom_range(0, 999) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Keypad front end that sits directly upstream of the ATM controller. It turns single key presses into the controller's request fields: language choice, account number, PIN, operation, destination account and amount. Each completed request is presented through a valid/ready handshake. The block also owns digit counting, field validation, amount range checking, cancel handling and the inactivity timeout.

## Interface
- TIMEOUT_CYCLES, 1000: cycles without `key_valid` before the session aborts. Must be ≥ 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; `key_code` is sampled on that edge.
- key_code  in  4  key value:
  - 0x0-0x9: digit.
  - 0xA: CLEAR.
  - 0xB: ENTER.
  - 0xC: CANCEL.
  - 0xD-0xF: ignored.
- atm_ready  in  1  controller accepts the presented request.
- LC  out  1  language chosen; held high for the whole session.
- lang  out  2  1 or 2 = selected language, 0 = none.
- Account_Number, PIN, Destination_Account  out  12 each  3-digit fields, each digit one nibble, MSD first.
- Deposit_Amount, WithDraw_Amount, Transfer_Amount  out  12 each  binary amount, routed by operation.
- Operation  out  3  0 deposit, 1 withdraw, 2 balance, 3 transfer, 4 exit.
- txn_valid  out  1  request presented.
- entry_state  out  3  current state:
  - LANG=0, ACCT=1, PINE=2, OP=3, DST=4, AMT=5, PRESENT=6.
- err  out  1  one-cycle pulse on a rejected key or ENTER.
- timeout  out  1  one-cycle pulse on an inactivity abort.

## Operation
- All outputs are registered. On reset every output is 0, state is LANG, and the digit count and accumulator are 0.
- Keys are only acted on when `key_valid`=1. Codes 0xD-0xF are ignored.
- CANCEL in any state aborts the session (see abort rule).
- CLEAR zeroes the field being entered and its digit count, and stays in the current state.
- **LANG**
  - Digit 1 or 2: `lang` takes the digit, `LC` goes to 1, go to ACCT.
  - Any other key: ignored.
- **ACCT, PINE, DST (hex fields)**
  - Each digit shifts in: `field <= {field[7:0], digit}`, count increments.
  - A 4th digit is ignored and pulses `err`.
  - ENTER with count=3: move on. ACCT→PINE, PINE→OP, DST→AMT.
  - ENTER with count<3: pulse `err`, clear the field, stay in the state.
- **OP**
  - A digit overwrites the pending opcode.
  - ENTER with no digit entered, or pending opcode >4: pulse `err`, stay.
  - Otherwise latch `Operation`, then:
    - 0 or 1 → AMT.
    - 3 → DST.
    - 2 or 4 → PRESENT.
- **AMT (decimal field, maximum 4095)**
  - Each digit: `acc <= acc*10 + d`, computed at 14-bit width.
  - If the result exceeds 4095, or 4 digits are already held: digit rejected, pulse `err`, `acc` unchanged.
  - ENTER with `acc`=0: pulse `err`, stay.
  - Otherwise `acc` is copied to the amount output selected by `Operation`, and the other two amount outputs are 0. Go to PRESENT.
- **PRESENT**
  - `txn_valid`=1 and all request outputs are held stable.
  - Keys other than CANCEL are ignored.
  - Transfer happens on an edge with `txn_valid` & `atm_ready`, after which:
    - `Operation`=4: abort to LANG with no `err` pulse.
    - Otherwise go to OP. `Account_Number`, `PIN`, `LC` and `lang` are kept; the amount outputs, `Destination_Account` and `Operation` are cleared.
  - If CANCEL arrives on the same edge as the handshake, the handshake wins; CANCEL is dropped.
- **Abort** (CANCEL, timeout, or exit transfer): next state is LANG and every output returns to its reset value. `timeout` pulses only on a timeout abort.

## Timing
- A key sampled on edge N is reflected in the outputs and `entry_state` after edge N. `err` is high during the cycle following edge N.
- `txn_valid` rises in the cycle after the accepting ENTER. It stays high until the first edge where `atm_ready`=1, and falls after that edge.
- The controller may hold `atm_ready` high continuously; the minimum PRESENT residency is then one cycle.
- Inactivity counter:
  - Clears on every `key_valid` and every state change.
  - Counts in ACCT, PINE, OP, DST and AMT only; held at 0 in LANG and PRESENT.
  - When it reaches TIMEOUT_CYCLES-1 without a key, the next edge aborts.
  - A key on that same edge wins and cancels the timeout.
- `rst` mid-session returns to the reset values on the next edge, regardless of state or handshake.

## Test plan
- **Basic withdraw.** Keys 1, 1,2,3,ENTER, 4,5,6,ENTER, 1,ENTER, 2,5,0,ENTER.
  - Required: PRESENT with `Account_Number`=0x123, `PIN`=0x456, `Operation`=1, `WithDraw_Amount`=250, other amounts 0.
  - `atm_ready`=1 → OP, account and PIN retained.
- **Transfer.** Operation 3, destination 7,8,9,ENTER, amount 4,0,9,5,ENTER.
  - Required: `Destination_Account`=0x789, `Transfer_Amount`=4095.
  - Repeat with 4,0,9,6: the final 6 pulses `err` and `acc` stays 409.
- **Field errors.**
  - Account 1,2,ENTER: `err` pulse, `Account_Number`=0, state ACCT.
  - Account 1,2,3,4: the 4 pulses `err`, field stays 0x123.
  - OP entry 7,ENTER: `err` pulse, state OP.
- **Handshake stall.** Hold `atm_ready`=0 for 5 cycles in PRESENT.
  - Required: `txn_valid` and all fields stable throughout.
  - Raise `atm_ready` together with CANCEL: transfer accepted, state OP.
- **Timeout.** TIMEOUT_CYCLES=8; enter two PIN digits, then idle.
  - Required: `timeout` pulse exactly 8 cycles after the last key; all outputs 0; state LANG.
  - A key at cycle 7 prevents the timeout.
- **Exit and reset.**
  - Operation 4 with ENTER, then handshake: LC drops to 0, state LANG.
  - `rst` asserted in AMT with `acc`=55: all outputs 0 after the next edge.
